// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared types and helpers for the multiplier-sharing controller.
//
// Contents:
//   state_e        - controller FSM state encoding (Idle, Issue, Wait, Resp)
//   DefaultDataW   - default operand/result width, matches the multiplier
//   MaxReq         - largest supported requester count
//   MaxDataW       - largest supported operand width
//   operand_slice  - selects operand slot idx of a packed operand bus
package mul_share_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned MaxReq       = 8;
  localparam int unsigned MaxDataW     = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  // Returns bits [idx*width +: width] of a packed operand bus, zero-extended to MaxDataW.
  // Callers zero-extend their own bus to MaxReq*MaxDataW bits first so a single
  // non-parameterized function serves every instance width.
  function automatic logic [MaxDataW-1:0] operand_slice(
    input logic [MaxReq*MaxDataW-1:0] bus,
    input int unsigned                idx,
    input int unsigned                width
  );
    logic [MaxDataW-1:0] mask;
    mask = {MaxDataW{1'b1}} >> (MaxDataW - width);
    return MaxDataW'(bus >> (idx * width)) & mask;
  endfunction

endpackage

// File: rtl/mul_share_ctrl_arb.sv
// rr_arbiter: combinational round-robin arbiter.
//
// The search starts at index ptr and wraps modulo N; the first requesting index wins.
// The pointer register is owned by the instantiating module.
//
// Ports:
//   req        in  N          request vector
//   ptr        in  clog2(N)   index searched first (must be < N)
//   grant      out N          one-hot grant, all zero when no request
//   grant_idx  out clog2(N)   encoded grant index, 0 when no request
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned SumW = IdxW + 1;

  logic [N-1:0]    rot;
  logic [IdxW-1:0] off;
  logic [SumW-1:0] sum;
  logic            found;

  always_comb begin
    // Rotate so that bit 0 of rot is requester ptr; a fixed priority search over
    // rot then implements the wrapping search.
    rot   = N'({req, req} >> ptr);
    off   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IdxW'(k);
      end
    end

    // Map the rotated offset back to an absolute index, modulo N.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SumW'(N)) begin
      sum = sum - SumW'(N);
    end

    grant_idx = found ? sum[IdxW-1:0] : '0;
    grant     = found ? (N'(1) << sum[IdxW-1:0]) : '0;
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one multiplier datapath between NUM_REQ requesters.
//
// One operand pair is accepted at a time by round-robin arbitration, the multiplier
// is started with a one-cycle pulse, and the result (or an error after a watchdog
// timeout) is returned to the winning requester as a one-cycle response.
// Handshake in cycle T gives mul_start in T+1 and resp_valid in T+4 for a
// multiplier that raises done two cycles after start.
//
// Ports:
//   clk         in   1               clock
//   reset       in   1               asynchronous active-high reset
//   req_valid   in   NUM_REQ         per-requester operand pair valid
//   req_ready   out  NUM_REQ         one-hot accept (Idle only)
//   req_a       in   NUM_REQ*DATA_W  packed operand A, slot i at [i*DATA_W +: DATA_W]
//   req_b       in   NUM_REQ*DATA_W  packed operand B, same packing
//   resp_valid  out  NUM_REQ         one-hot one-cycle response pulse
//   resp_data   out  DATA_W          product, 0 on error; holds until next response
//   resp_err    out  1               watchdog fired, qualified by resp_valid
//   mul_start   out  1               one-cycle multiplier start
//   mul_a       out  DATA_W          operand A, held from accept until the next accept
//   mul_b       out  DATA_W          operand B, same hold rule
//   mul_done    in   1               multiplier done pulse (ignored outside Wait)
//   mul_result  in   DATA_W          multiplier result
//   busy        out  1               high whenever the controller is not idle
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  output logic                      mul_start,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic                      mul_done,
  input  logic [DATA_W-1:0]         mul_result,
  output logic                      busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT);

  // Last Wait-cycle count value; reaching it without done ends the operation.
  localparam logic [CntW-1:0] CountLast = CntW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_REQ - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     id_q, id_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0]           arb_grant;
  logic [IdxW-1:0]              arb_idx;
  logic [MaxReq*MaxDataW-1:0]   req_a_ext;
  logic [MaxReq*MaxDataW-1:0]   req_b_ext;
  logic [DATA_W-1:0]            sel_a;
  logic [DATA_W-1:0]            sel_b;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Operand slot of the current arbitration winner.
  always_comb begin
    req_a_ext = '0;
    req_b_ext = '0;
    req_a_ext[NUM_REQ*DATA_W-1:0] = req_a;
    req_b_ext[NUM_REQ*DATA_W-1:0] = req_b;
    sel_a = DATA_W'(operand_slice(req_a_ext, 32'(arb_idx), DATA_W));
    sel_b = DATA_W'(operand_slice(req_b_ext, 32'(arb_idx), DATA_W));
  end

  // Next-state and Moore/Mealy outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    count_d     = count_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    req_ready   = '0;
    resp_valid  = '0;
    mul_start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The grant is already qualified by req_valid, so any grant is a handshake.
        req_ready = arb_grant;
        if (|arb_grant) begin
          mul_a_d = sel_a;
          mul_b_d = sel_b;
          id_d    = arb_idx;
          ptr_d   = (arb_idx == IdxLast) ? '0 : arb_idx + 1'b1;
          state_d = StIssue;
        end
      end

      StIssue: begin
        mul_start = 1'b1;
        count_d   = '0;
        state_d   = StWait;
      end

      StWait: begin
        // done is checked first so a done on the final watchdog cycle still succeeds.
        if (mul_done) begin
          resp_data_d = mul_result;
          resp_err_d  = 1'b0;
          state_d     = StResp;
        end else if (count_q == CountLast) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = StResp;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      StResp: begin
        resp_valid = NUM_REQ'(1) << id_q;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      count_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      count_q     <= count_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign resp_data = resp_data_q;
  // The error flag is only meaningful alongside a response pulse.
  assign resp_err  = resp_err_q & (state_q == StResp);
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Shares one matrix_multiplier datapath between NUM_REQ requesters, e.g. core execute stage, DMA engine and debug port.
- Round-robin arbitration accepts one operand pair at a time, pulses the multiplier start, waits for done and returns the result to the winning requester.
- A watchdog timeout guards against a hung datapath.
- Sits between the requesters and the multiplier instance.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 32, operand/result width; must match the multiplier.
- TIMEOUT, 16, max WAIT-state cycles before an error response (>=4).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand-pair valid
- req_ready  out  NUM_REQ  one-hot accept; at most one bit high
- req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed operand B, same packing
- resp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
- resp_data  out  DATA_W  signed product; 0 on error
- resp_err  out  1  high with resp_valid when the watchdog fired
- mul_start  out  1  one-cycle start to the multiplier
- mul_a  out  DATA_W  operand A to the multiplier, held from ISSUE until next accept
- mul_b  out  DATA_W  operand B to the multiplier, same hold rule
- mul_done  in  1  multiplier done pulse
- mul_result  in  DATA_W  multiplier result
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - state=IDLE; req_ready, resp_valid, resp_err, mul_start = 0.
  - mul_a, mul_b, resp_data = 0; rr pointer = 0; watchdog count = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: a one-hot grant from round-robin over req_valid.
  - Search starts at index ptr and wraps modulo NUM_REQ.
  - Handshake is req_valid[i] & req_ready[i]. On handshake:
    - capture req_a/req_b slice i into mul_a/mul_b;
    - record id=i;
    - ptr <= (i+1) mod NUM_REQ;
    - go to ISSUE.
  - No valid request: stay in IDLE, ptr unchanged.
- ISSUE:
  - mul_start=1 for exactly this cycle; req_ready=0; count cleared.
  - Next state is WAIT.
- WAIT:
  - mul_start=0. Each cycle without mul_done, count increments.
  - mul_done=1: register mul_result into resp_data, resp_err<=0, go to RESP.
  - count reaches TIMEOUT-1 without done: resp_data<=0, resp_err<=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - resp_valid[id]=1 for one cycle, with resp_data/resp_err valid; no backpressure.
  - Next state is IDLE. resp_data holds until the next response.
- Latency (handshake in cycle T): mul_start high in T+1, multiplier done seen in T+3, resp_valid in T+4, earliest next handshake in T+5.
  - Peak throughput is one operation per 5 cycles.
- mul_done outside WAIT (e.g. a late done after a timeout) is ignored; no response, no state change.
- req_valid dropping before handshake is legal; no accept is recorded.
- Requesters must hold operands stable until handshake.
- Fairness: with all NUM_REQ requesting continuously, grants rotate 0,1,2,0,... and none waits more than NUM_REQ-1 operations.
- Arithmetic is the multiplier's: signed DATA_W x DATA_W, low DATA_W bits. The controller performs no arithmetic.
- Reset mid-operation:
  - immediate return to IDLE; any in-flight response is lost with no resp_valid;
  - ptr returns to 0;
  - the multiplier shares the reset and is cleared too.

Decomposition:
- Package mul_share_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - DATA_W default constant;
  - helper function for packed-operand slice selection.
- One sub-module, rr_arbiter:
  - parameter N; inputs req[N] and ptr; output one-hot grant[N] and encoded grant index.
  - Purely combinational; the pointer register lives in mul_share_ctrl.

Test Plan:
- Single op: req 1 sends A=7, B=-3 -> mul_start in T+1, resp_valid[1] in T+4, resp_data=-21 (0xFFFFFFEB), resp_err=0.
- Round-robin: all three requesters valid continuously with distinct operands (2x3, 4x5, 6x7) -> grants 0,1,2,0, responses 6, 20, 42 to the matching ids, 5 cycles apart.
- Timeout: mul_done tied low -> after TIMEOUT WAIT cycles, resp_valid[id]=1, resp_err=1, resp_data=0; a forced mul_done one cycle later -> no response, state stays IDLE.
- Overflow/signed: A=0x7FFFFFFF, B=2 -> resp_data=0xFFFFFFFE; A=-1, B=-1 -> 1.
- Reset mid-WAIT: assert reset one cycle after mul_start -> busy=0 and no resp_valid; a new request from req 2 after release is granted, with ptr back at 0.
- Fairness under churn: req 0 always valid, req 2 pulses valid -> req 2 is granted within 2 operations of raising valid.
